// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder sequencer: drives one external 4-bit adder
// LSB nibble first, chains the carry in a register and hands back sum/cout.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_c,
    input  logic [3:0]       add_s,
    input  logic             add_cy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] acc_next_s;

    function automatic logic [3:0] get_nib(input logic [WIDTH-1:0] vec,
                                           input logic [IDX_W-1:0] i);
        get_nib = vec[{i, 2'b00} +: 4];
    endfunction

    function automatic logic [WIDTH-1:0] put_nib(input logic [WIDTH-1:0] vec,
                                                 input logic [IDX_W-1:0] i,
                                                 input logic [3:0]       n);
        put_nib = vec;
        put_nib[{i, 2'b00} +: 4] = n;
    endfunction

    // Accumulator with the current adder nibble merged in; on the last pass
    // this is the complete result, so no variable-width slice is needed.
    always_comb begin
        acc_next_s = put_nib(acc_r, idx_r, add_s);
    end

    // Adder operand drive, forced to zero outside RUN.
    always_comb begin
        add_a = 4'h0;
        add_b = 4'h0;
        add_c = 1'b0;
        if (state_r == ST_RUN) begin
            add_a = get_nib(a_r, idx_r);
            add_b = get_nib(b_r, idx_r);
            add_c = carry_r;
        end else begin
            add_a = 4'h0;
            add_b = 4'h0;
            add_c = 1'b0;
        end
    end

    // Sequencer with registered status flags updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDX_W{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= cin;
                        idx_r   <= {IDX_W{1'b0}};
                        acc_r   <= {WIDTH{1'b0}};
                        state_r <= ST_RUN;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                    done_r <= 1'b0;
                end
                ST_RUN: begin
                    acc_r   <= acc_next_s;
                    carry_r <= add_cy;
                    if (idx_r == LAST_IDX) begin
                        // Carry out of the top nibble goes to cout only.
                        sum_r   <= acc_next_s;
                        cout_r  <= add_cy;
                        idx_r   <= {IDX_W{1'b0}};
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    idx_r   <= {IDX_W{1'b0}};
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign cout  = cout_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with an inline
// behavioural four_bit_adder on the add_* ports.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic [3:0]  add_a;
    logic [3:0]  add_b;
    logic        add_c;
    logic [3:0]  add_s;
    logic        add_cy;

    int errors = 0;
    int checks = 0;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .ready(ready), .busy(busy), .done(done), .sum(sum), .cout(cout),
        .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .add_s(add_s), .add_cy(add_cy)
    );

    assign {add_cy, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'b0000, add_c};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and check latency, busy length, hold of the old
    // result during RUN and the final sum/cout; returns with state IDLE.
    task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [15:0] prev_sum,
                          input logic [15:0] exp_sum, input logic exp_cout);
        int n;
        int bc;
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        bc = (busy === 1'b1) ? 1 : 0;
        chk({tag, "_held"}, {16'h0, sum}, {16'h0, prev_sum});
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
            if (busy === 1'b1) bc++;
        end
        chk({tag, "_lat"}, n, 4);
        chk({tag, "_busy"}, bc, 4);
        chk({tag, "_sum"}, {16'h0, sum}, {16'h0, exp_sum});
        chk({tag, "_cout"}, {31'h0, cout}, {31'h0, exp_cout});
        tick();
        chk({tag, "_idle"}, {30'h0, ready, done}, 32'h2);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
        #12;
        chk("rst_flags", {29'h0, ready, busy, done}, 32'h4);
        chk("rst_sum", {15'h0, cout, sum}, 32'h0);
        chk("rst_adder", {23'h0, add_a, add_b, add_c}, 32'h0);
        rst_n = 1'b1;
        tick();

        // T1: zero operands, latency and busy length
        run_op("t1", 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);

        // T3 + T5: nibble sequence 4,3,2,1 and a start during RUN that is ignored
        a = 16'h1234; b = 16'h4321; cin = 1'b1; start = 1'b1;
        tick();
        chk("t3_an0", {28'h0, add_a}, 32'h4);
        chk("t3_c0", {31'h0, add_c}, 32'h1);
        a = 16'h0001; b = 16'h0001; cin = 1'b0;
        tick();
        chk("t3_an1", {28'h0, add_a}, 32'h3);
        tick();
        chk("t3_an2", {28'h0, add_a}, 32'h2);
        tick();
        chk("t3_an3", {28'h0, add_a}, 32'h1);
        chk("t3_bn3", {28'h0, add_b}, 32'h4);
        tick();
        chk("t3_done", {30'h0, done, busy}, 32'h2);
        chk("t3_sum", {16'h0, sum}, 32'h5556);
        chk("t3_cout", {31'h0, cout}, 32'h0);
        start = 1'b0;
        tick();
        chk("t5_idle", {29'h0, ready, busy, done}, 32'h4);
        tick();
        chk("t5_nodone", {29'h0, ready, busy, done}, 32'h4);
        chk("t5_sum", {16'h0, sum}, 32'h5556);

        // T2: full carry ripple, old result held during RUN
        run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h5556, 16'h0000, 1'b1);

        // T4: all ones with carry-in, start held high for a back-to-back op
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        tick();
        a = 16'h0001; b = 16'h0002; cin = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        chk("t4_lat", n, 4);
        chk("t4_sum", {16'h0, sum}, 32'hFFFF);
        chk("t4_cout", {31'h0, cout}, 32'h1);
        n = 0;
        tick(); n++;
        while (done !== 1'b1 && n < 20) begin tick(); n++; end
        start = 1'b0;
        chk("t4_b2b", n, 6);
        chk("t4_sum2", {16'h0, sum}, 32'h0003);
        chk("t4_cout2", {31'h0, cout}, 32'h0);
        tick();
        tick();
        chk("t4_stop", {29'h0, ready, busy, done}, 32'h4);

        // T6: reset in the second RUN cycle
        a = 16'h000F; b = 16'h0001; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("t6_pre", {23'h0, add_a, add_b, add_c}, {23'h0, 4'h0, 4'h0, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("t6_flags", {29'h0, ready, busy, done}, 32'h4);
        chk("t6_sum", {15'h0, cout, sum}, 32'h0);
        chk("t6_adder", {23'h0, add_a, add_b, add_c}, 32'h0);
        #2;
        rst_n = 1'b1;
        tick();
        run_op("t6", 16'h00FF, 16'h0001, 1'b0, 16'h0000, 16'h0100, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
